// File: rtl/mmio_port_bank.sv
// Memory-mapped I/O bank: writable output channels, synchronised input channels with
// sticky rising-edge capture (write-1-to-clear), a maskable interrupt and one-cycle read data.
module mmio_port_bank #(
  parameter int unsigned DBITS       = 32,
  parameter logic [31:0] BASE_ADDR   = 32'hF000_0000,
  parameter int unsigned NUM_OUT     = 3,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned NUM_IN      = 2,
  parameter int unsigned IN_WIDTH    = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wrEn,
  input  logic                           rdEn,
  input  logic [DBITS-1:0]               addr,
  input  logic [DBITS-1:0]               wrData,
  output logic [DBITS-1:0]               rdData,
  output logic                           rdHit,
  output logic [NUM_OUT*OUT_WIDTH-1:0]   outBus,
  input  logic [NUM_IN*IN_WIDTH-1:0]     inBus,
  output logic                           irq
);

  localparam int unsigned WarmMax = SYNC_STAGES + 1;
  localparam int unsigned WarmW   = $clog2(WarmMax + 1);

  logic [OUT_WIDTH-1:0] out_q  [NUM_OUT];
  logic [IN_WIDTH-1:0]  sync_q [NUM_IN][SYNC_STAGES];
  logic [IN_WIDTH-1:0]  prev_q [NUM_IN];
  logic [IN_WIDTH-1:0]  edge_q [NUM_IN];
  logic [IN_WIDTH-1:0]  edge_d [NUM_IN];
  logic [NUM_IN-1:0]    mask_q;
  logic [WarmW-1:0]     warm_q;
  logic [DBITS-1:0]     rd_data_q;
  logic                 rd_hit_q;
  logic                 irq_q;

  logic [DBITS-1:0]     off;
  logic [DBITS-5:0]     blk;
  logic [1:0]           idx;
  logic                 aligned;
  logic                 out_hit, in_hit, edge_hit, mask_hit;
  logic                 armed;
  logic [DBITS-1:0]     rd_val;
  logic                 rd_hit;
  logic [NUM_IN-1:0]    edge_any;
  logic                 irq_d;
  logic                 unused_wdata;

  // Upper write-data bits are meaningless for narrow channels.
  assign unused_wdata = ^wrData;

  assign off     = addr - BASE_ADDR[DBITS-1:0];
  assign blk     = off[DBITS-1:4];
  assign idx     = off[3:2];
  assign aligned = (addr[1:0] == 2'b00);

  assign out_hit  = aligned && (blk == '0) && ({30'd0, idx} < NUM_OUT);
  assign in_hit   = aligned && (blk == (DBITS-4)'(1)) && ({30'd0, idx} < NUM_IN);
  assign edge_hit = aligned && (blk == (DBITS-4)'(2)) && ({30'd0, idx} < NUM_IN);
  assign mask_hit = aligned && (blk == (DBITS-4)'(3)) && (idx == 2'd0);

  assign armed = (warm_q == WarmW'(WarmMax));

  // Set beats clear when both land on the same bit in the same cycle.
  always_comb begin
    for (int j = 0; j < NUM_IN; j++) begin
      logic [IN_WIDTH-1:0] clr;
      logic [IN_WIDTH-1:0] rise;
      clr  = (wrEn && edge_hit && (idx == 2'(j))) ? wrData[IN_WIDTH-1:0] : '0;
      rise = armed ? (sync_q[j][SYNC_STAGES-1] & ~prev_q[j]) : '0;
      edge_d[j]   = (edge_q[j] & ~clr) | rise;
      edge_any[j] = |edge_q[j];
    end
    irq_d = |(mask_q & edge_any);
  end

  always_comb begin
    rd_val = '0;
    rd_hit = out_hit | in_hit | edge_hit | mask_hit;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (out_hit && (idx == 2'(i))) rd_val[OUT_WIDTH-1:0] = out_q[i];
    end
    for (int j = 0; j < NUM_IN; j++) begin
      if (in_hit && (idx == 2'(j)))   rd_val[IN_WIDTH-1:0] = sync_q[j][SYNC_STAGES-1];
      if (edge_hit && (idx == 2'(j))) rd_val[IN_WIDTH-1:0] = edge_q[j];
    end
    if (mask_hit) rd_val[NUM_IN-1:0] = mask_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
      for (int j = 0; j < NUM_IN; j++) begin
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[j][s] <= '0;
        prev_q[j] <= '0;
        edge_q[j] <= '0;
      end
      mask_q    <= '0;
      warm_q    <= '0;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (wrEn && out_hit && (idx == 2'(i))) out_q[i] <= wrData[OUT_WIDTH-1:0];
      end
      for (int j = 0; j < NUM_IN; j++) begin
        sync_q[j][0] <= inBus[j*IN_WIDTH +: IN_WIDTH];
        for (int s = 1; s < SYNC_STAGES; s++) sync_q[j][s] <= sync_q[j][s-1];
        prev_q[j] <= sync_q[j][SYNC_STAGES-1];
        edge_q[j] <= edge_d[j];
      end
      if (wrEn && mask_hit) mask_q <= wrData[NUM_IN-1:0];
      if (!armed) warm_q <= warm_q + 1'b1;
      if (rdEn) begin
        rd_data_q <= rd_val;
        rd_hit_q  <= rd_hit;
      end
      irq_q <= irq_d;
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    assign outBus[i*OUT_WIDTH +: OUT_WIDTH] = out_q[i];
  end

  assign rdData = rd_data_q;
  assign rdHit  = rd_hit_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed self-checking bench for mmio_port_bank at its default parameters.
module tb_mmio_port_bank;

  localparam logic [31:0] Base = 32'hF000_0000;

  logic        clk;
  logic        reset;
  logic        wrEn;
  logic        rdEn;
  logic [31:0] addr;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        rdHit;
  logic [47:0] outBus;
  logic [19:0] inBus;
  logic        irq;

  int checks;
  int failures;

  mmio_port_bank dut (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (wrEn),
    .rdEn   (rdEn),
    .addr   (addr),
    .wrData (wrData),
    .rdData (rdData),
    .rdHit  (rdHit),
    .outBus (outBus),
    .inBus  (inBus),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wrData = d; wrEn = 1'b1;
    tick(1);
    wrEn = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    addr = a; rdEn = 1'b1;
    tick(1);
    rdEn = 1'b0;
    d = rdData;
    h = rdHit;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic h;
    inBus = '1; reset = 1'b0;
    tick(3);
    reset = 1'b1;
    checks++; if (outBus !== 48'h0) begin failures++; $display("FAIL rst_outbus got=%h exp=0", outBus); end
    checks++; if (rdData !== 32'h0) begin failures++; $display("FAIL rst_rddata got=%h exp=0", rdData); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
    tick(8);
    bus_read(Base + 32'h20, d, h);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_edge0 got=%h exp=0", d); end
    bus_read(Base + 32'h24, d, h);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_edge1 got=%h exp=0", d); end
    bus_read(Base + 32'h10, d, h);
    checks++; if (d !== 32'h3FF || h !== 1'b1) begin failures++; $display("FAIL rst_in0 got=%h/%b exp=3ff/1", d, h); end
    inBus = '0;
    tick(4);
  endtask

  task automatic test_output();
    logic [31:0] d; logic h;
    bus_write(Base + 32'h04, 32'h1234_ABCD);
    checks++; if (outBus !== 48'h0000_ABCD_0000) begin failures++; $display("FAIL out1_bus got=%h exp=0000abcd0000", outBus); end
    bus_read(Base + 32'h04, d, h);
    checks++; if (d !== 32'h0000_ABCD || h !== 1'b1) begin failures++; $display("FAIL out1_read got=%h/%b exp=0000abcd/1", d, h); end
    bus_write(Base + 32'h00, 32'h0000_5555);
    bus_write(Base + 32'h08, 32'hFFFF_1111);
    checks++; if (outBus !== 48'h1111_ABCD_5555) begin failures++; $display("FAIL out_all got=%h exp=1111abcd5555", outBus); end
    bus_read(Base + 32'h08, d, h);
    checks++; if (d !== 32'h0000_1111) begin failures++; $display("FAIL out2_read got=%h exp=00001111", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic h;
    addr = Base + 32'h08; wrData = 32'h0000_2222; wrEn = 1'b1; rdEn = 1'b1;
    tick(1);
    wrEn = 1'b0; rdEn = 1'b0;
    checks++; if (rdData !== 32'h0000_1111) begin failures++; $display("FAIL rw_same_old got=%h exp=00001111", rdData); end
    checks++; if (outBus !== 48'h2222_ABCD_5555) begin failures++; $display("FAIL rw_same_bus got=%h exp=2222abcd5555", outBus); end
    tick(2);
    checks++; if (rdData !== 32'h0000_1111) begin failures++; $display("FAIL rd_hold got=%h exp=00001111", rdData); end
    bus_read(Base + 32'h08, d, h);
    checks++; if (d !== 32'h0000_2222) begin failures++; $display("FAIL rw_same_new got=%h exp=00002222", d); end
    addr = Base + 32'h00; rdEn = 1'b1;
    tick(1);
    checks++; if (rdData !== 32'h0000_5555) begin failures++; $display("FAIL b2b_rd0 got=%h exp=00005555", rdData); end
    addr = Base + 32'h04;
    tick(1);
    rdEn = 1'b0;
    checks++; if (rdData !== 32'h0000_ABCD) begin failures++; $display("FAIL b2b_rd1 got=%h exp=0000abcd", rdData); end
  endtask

  task automatic test_input_edge();
    logic [31:0] d; logic h;
    bus_write(Base + 32'h30, 32'h2);
    bus_read(Base + 32'h30, d, h);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL mask_read got=%h exp=2", d); end
    inBus = 20'h02000;  // ch1 bit 3 rises, first sampled at edge t
    tick(1);            // t
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL in_irq_t got=%b exp=0", irq); end
    tick(1);            // t+1
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL in_irq_t1 got=%b exp=0", irq); end
    addr = Base + 32'h14; rdEn = 1'b1;
    tick(1);            // t+2
    checks++; if (rdData !== 32'h008 || rdHit !== 1'b1) begin failures++; $display("FAIL in1_read got=%h/%b exp=008/1", rdData, rdHit); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL in_irq_t2 got=%b exp=0", irq); end
    addr = Base + 32'h24;
    tick(1);            // t+3
    rdEn = 1'b0;
    checks++; if (rdData !== 32'h008) begin failures++; $display("FAIL edge1_read got=%h exp=008", rdData); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL in_irq_t3 got=%b exp=1", irq); end
    bus_read(Base + 32'h20, d, h);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL edge0_quiet got=%h exp=0", d); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] d; logic h;
    bus_write(Base + 32'h24, 32'h3FF);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL w1c_irq_same got=%b exp=1", irq); end
    tick(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_next got=%b exp=0", irq); end
    bus_write(Base + 32'h30, 32'h1);
    inBus = 20'h02001;
    tick(4);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL edge0_irq got=%b exp=1", irq); end
    inBus = 20'h02000;
    tick(4);
    inBus = 20'h02001;  // rise sampled at t; EDGE set lands at t+2
    tick(2);
    bus_write(Base + 32'h20, 32'h1);  // clear lands at t+2 too
    bus_read(Base + 32'h20, d, h);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL race_set_wins got=%h exp=1", d); end
    bus_write(Base + 32'h20, 32'h1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL clr_irq_same got=%b exp=1", irq); end
    tick(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clr_irq_next got=%b exp=0", irq); end
    bus_read(Base + 32'h20, d, h);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL clr_edge0 got=%h exp=0", d); end
  endtask

  task automatic test_decode();
    logic [31:0] d; logic h;
    bus_write(Base + 32'h02, 32'hFFFF_FFFF);
    bus_write(Base + 32'h40, 32'hFFFF_FFFF);
    bus_write(Base + 32'h10, 32'hFFFF_FFFF);
    checks++; if (outBus !== 48'h2222_ABCD_5555) begin failures++; $display("FAIL dec_outbus got=%h exp=2222abcd5555", outBus); end
    bus_read(Base + 32'h40, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b0) begin failures++; $display("FAIL dec_rd40 got=%h/%b exp=0/0", d, h); end
    bus_read(Base + 32'h30, d, h);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL dec_mask got=%h exp=1", d); end
    bus_read(Base + 32'h10, d, h);
    checks++; if (d !== 32'h001 || h !== 1'b1) begin failures++; $display("FAIL dec_in0 got=%h/%b exp=001/1", d, h); end
    bus_read(Base + 32'h34, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b0) begin failures++; $display("FAIL dec_rd34 got=%h/%b exp=0/0", d, h); end
    bus_read(Base - 32'h4, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b0) begin failures++; $display("FAIL dec_below got=%h/%b exp=0/0", d, h); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d; logic h;
    inBus = 20'h02000;
    tick(4);
    bus_write(Base + 32'h00, 32'h0000_FFFF);
    inBus = 20'h02003;
    tick(4);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mid_pre_irq got=%b exp=1", irq); end
    bus_read(Base + 32'h20, d, h);
    checks++; if (d !== 32'h3) begin failures++; $display("FAIL mid_pre_edge0 got=%h exp=3", d); end
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    checks++; if (outBus !== 48'h0) begin failures++; $display("FAIL mid_outbus got=%h exp=0", outBus); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_irq got=%b exp=0", irq); end
    checks++; if (rdData !== 32'h0 || rdHit !== 1'b0) begin failures++; $display("FAIL mid_rd got=%h/%b exp=0/0", rdData, rdHit); end
    bus_write(Base + 32'h30, 32'h3);
    for (int c = 0; c < 5; c++) begin
      tick(1);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_warm_irq c=%0d got=%b exp=0", c, irq); end
    end
    bus_read(Base + 32'h20, d, h);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL mid_edge0 got=%h exp=0", d); end
    bus_read(Base + 32'h24, d, h);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL mid_edge1 got=%h exp=0", d); end
    bus_read(Base + 32'h00, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b1) begin failures++; $display("FAIL mid_out0 got=%h/%b exp=0/1", d, h); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; wrEn = 1'b0; rdEn = 1'b0; addr = '0; wrData = '0; inBus = '0;
    @(posedge clk); #1;
    test_reset();
    test_output();
    test_back_to_back();
    test_input_edge();
    test_w1c_race();
    test_decode();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
